// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : BCD score / lines / level keeper. Accepts one lines-cleared
//               event per handshake, accumulates with a digit-serial BCD
//               adder on shadow copies, and commits all three arrays in
//               one cycle so the renderer never sees a half-updated number.
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int NUMBER_LEN      = 6,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MULT_CAP        = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       new_game_i,
    input  logic                       event_valid_i,
    input  logic [2:0]                 event_lines_i,
    output logic                       event_ready_o,
    output logic                       done_o,
    output logic [NUMBER_LEN-1:0][3:0] score_o,
    output logic [NUMBER_LEN-1:0][3:0] lines_o,
    output logic [NUMBER_LEN-1:0][3:0] level_o
);

    localparam int             DW           = $clog2(NUMBER_LEN);
    localparam logic [DW-1:0]  c_LAST_DIGIT = DW'(NUMBER_LEN - 1);
    localparam logic [3:0]     c_MULT_MAX   = 4'(MULT_CAP - 1);
    localparam logic [8:0]     c_LPL        = 9'(LINES_PER_LEVEL);
    localparam logic [NUMBER_LEN*4-1:0] c_ALL_NINES = {NUMBER_LEN{4'h9}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADD   = 3'd1,
        ST_LINES = 3'd2,
        ST_LEVEL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                      r_state;
    logic                        r_ready;
    logic                        r_done;
    logic [NUMBER_LEN-1:0][3:0]  r_score;
    logic [NUMBER_LEN-1:0][3:0]  r_lines;
    logic [NUMBER_LEN-1:0][3:0]  r_level;
    logic [NUMBER_LEN-1:0][3:0]  r_sh_score;
    logic [NUMBER_LEN-1:0][3:0]  r_sh_lines;
    logic [3:0][3:0]             r_base;
    logic [2:0]                  r_n;
    logic [3:0]                  r_mult;
    logic [3:0]                  r_pass;
    logic [DW-1:0]               r_digit;
    logic                        r_carry;
    logic [7:0]                  r_lines_to_next;
    logic [3:0]                  r_level_bin;

    logic [2:0]                  w_n_clamped;
    logic [3:0]                  w_mult;
    logic [15:0]                 w_base;
    logic [7:0]                  w_digit_ext;
    logic [3:0]                  w_op_a;
    logic [3:0]                  w_op_b;
    logic [4:0]                  w_sum;
    logic                        w_dig_carry;
    logic [3:0]                  w_dig;
    logic [NUMBER_LEN-1:0][3:0]  w_level_inc;
    logic                        w_inc_carry;
    logic                        w_level_up;
    logic [7:0]                  w_ltn_wrap;

    assign event_ready_o = r_ready;
    assign done_o        = r_done;
    assign score_o       = r_score;
    assign lines_o       = r_lines;
    assign level_o       = r_level;

    // Event decode at accept: clamp line count, pick multiplier and base points
    always_comb begin
        w_n_clamped = (event_lines_i > 3'd4) ? 3'd4 : event_lines_i;
        w_mult      = ((r_level_bin > c_MULT_MAX) ? c_MULT_MAX : r_level_bin) + 4'd1;
        case (w_n_clamped)
            3'd1:    w_base = 16'h0040;
            3'd2:    w_base = 16'h0100;
            3'd3:    w_base = 16'h0300;
            3'd4:    w_base = 16'h1200;
            default: w_base = 16'h0000;
        endcase
    end

    // Shared one-digit BCD adder: score digits in ADD, lines digits in LINES
    always_comb begin
        w_digit_ext = 8'(r_digit);
        if (r_state == ST_LINES) begin
            w_op_a = r_sh_lines[r_digit];
            w_op_b = (r_digit == '0) ? {1'b0, r_n} : 4'd0;
        end else begin
            w_op_a = r_sh_score[r_digit];
            w_op_b = (w_digit_ext < 8'd4) ? r_base[r_digit[1:0]] : 4'd0;
        end
        w_sum       = {1'b0, w_op_a} + {1'b0, w_op_b} + {4'd0, r_carry};
        w_dig_carry = (w_sum > 5'd9);
        w_dig       = w_dig_carry ? 4'(w_sum - 5'd10) : w_sum[3:0];
    end

    // Level increment (ripple, saturating) and lines-to-next bookkeeping
    always_comb begin
        w_level_inc = r_level;
        w_inc_carry = 1'b1;
        for (int i = 0; i < NUMBER_LEN; i++) begin
            if (w_inc_carry) begin
                if (r_level[i] == 4'd9) begin
                    w_level_inc[i] = 4'd0;
                end else begin
                    w_level_inc[i] = r_level[i] + 4'd1;
                    w_inc_carry    = 1'b0;
                end
            end
        end
        if (w_inc_carry) begin
            w_level_inc = c_ALL_NINES;
        end
        w_level_up = (r_lines_to_next <= {5'd0, r_n});
        w_ltn_wrap = 8'({1'b0, r_lines_to_next} + c_LPL - {6'd0, r_n});
    end

    // Control FSM: handshake, serial add passes, level update and atomic commit
    always_ff @(posedge clk_i) begin
        if (rst_i || new_game_i) begin
            r_state         <= ST_IDLE;
            r_ready         <= 1'b1;
            r_done          <= 1'b0;
            r_score         <= '0;
            r_lines         <= '0;
            r_level         <= '0;
            r_sh_score      <= '0;
            r_sh_lines      <= '0;
            r_base          <= '0;
            r_n             <= '0;
            r_mult          <= '0;
            r_pass          <= '0;
            r_digit         <= '0;
            r_carry         <= 1'b0;
            r_lines_to_next <= 8'(LINES_PER_LEVEL);
            r_level_bin     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (event_valid_i && r_ready) begin
                        r_n        <= w_n_clamped;
                        r_mult     <= w_mult;
                        r_base     <= w_base;
                        r_sh_score <= r_score;
                        r_sh_lines <= r_lines;
                        r_digit    <= '0;
                        r_pass     <= '0;
                        r_carry    <= 1'b0;
                        r_ready    <= 1'b0;
                        if (w_n_clamped == 3'd0) begin
                            // Nothing to add; outputs already hold the result
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_ADD;
                        end
                    end
                end
                ST_ADD: begin
                    r_sh_score[r_digit] <= w_dig;
                    r_carry             <= w_dig_carry;
                    if (r_digit == c_LAST_DIGIT) begin
                        r_digit <= '0;
                        r_carry <= 1'b0;
                        if (w_dig_carry) begin
                            // Overflow: pin to all 9s, further passes cannot help
                            r_sh_score <= c_ALL_NINES;
                            r_state    <= ST_LINES;
                        end else if (r_pass + 4'd1 == r_mult) begin
                            r_state <= ST_LINES;
                        end else begin
                            r_pass <= r_pass + 4'd1;
                        end
                    end else begin
                        r_digit <= r_digit + DW'(1);
                    end
                end
                ST_LINES: begin
                    r_sh_lines[r_digit] <= w_dig;
                    r_carry             <= w_dig_carry;
                    if (r_digit == c_LAST_DIGIT) begin
                        r_digit <= '0;
                        r_carry <= 1'b0;
                        if (w_dig_carry) begin
                            r_sh_lines <= c_ALL_NINES;
                        end
                        r_state <= ST_LEVEL;
                    end else begin
                        r_digit <= r_digit + DW'(1);
                    end
                end
                ST_LEVEL: begin
                    // Level only moves here, so the output register doubles as
                    // its shadow; all three arrays land on the same edge.
                    r_score <= r_sh_score;
                    r_lines <= r_sh_lines;
                    if (w_level_up) begin
                        r_level         <= w_level_inc;
                        r_level_bin     <= (r_level_bin == 4'd15) ? 4'd15 : r_level_bin + 4'd1;
                        r_lines_to_next <= w_ltn_wrap;
                    end else begin
                        r_lines_to_next <= r_lines_to_next - {5'd0, r_n};
                    end
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_keeper
// Description : Directed self-checking bench for score_keeper (N=6 and N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ng  = 1'b0;
    logic             ev  = 1'b0;
    logic [2:0]       el  = 3'd0;
    logic             rdy;
    logic             dn;
    logic [5:0][3:0]  score;
    logic [5:0][3:0]  lines;
    logic [5:0][3:0]  level;

    logic             ng4 = 1'b0;
    logic             ev4 = 1'b0;
    logic [2:0]       el4 = 3'd0;
    logic             rdy4;
    logic             dn4;
    logic [3:0][3:0]  score4;
    logic [3:0][3:0]  lines4;
    logic [3:0][3:0]  level4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    score_keeper #(.NUMBER_LEN(6), .LINES_PER_LEVEL(10), .MULT_CAP(10)) dut (
        .clk_i(clk), .rst_i(rst), .new_game_i(ng), .event_valid_i(ev),
        .event_lines_i(el), .event_ready_o(rdy), .done_o(dn),
        .score_o(score), .lines_o(lines), .level_o(level)
    );

    score_keeper #(.NUMBER_LEN(4), .LINES_PER_LEVEL(10), .MULT_CAP(10)) dut4 (
        .clk_i(clk), .rst_i(rst), .new_game_i(ng4), .event_valid_i(ev4),
        .event_lines_i(el4), .event_ready_o(rdy4), .done_o(dn4),
        .score_o(score4), .lines_o(lines4), .level_o(level4)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Offer one event; lat = cycles from accept cycle T to the done cycle.
    task automatic send(input logic [2:0] n, output int lat, output int rdy_hi, output int changes);
        logic [23:0] s0, l0, v0;
        int g;
        s0 = score; l0 = lines; v0 = level;
        @(negedge clk); ev = 1'b1; el = n;
        g = 0;
        while (!rdy && g < 500) begin @(negedge clk); g++; end
        @(posedge clk); #1 ev = 1'b0; el = 3'd0;
        lat = 0; rdy_hi = 0; changes = 0;
        while (lat < 200) begin
            @(negedge clk); lat++;
            if (dn) break;
            if (rdy) rdy_hi++;
            if (score !== s0 || lines !== l0 || level !== v0) changes++;
        end
    endtask

    task automatic do_clear();
        @(negedge clk); ng = 1'b1;
        @(negedge clk); ng = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (score !== 24'h0) begin bad++; $display("FAIL reset_score: got %h want 000000", score); end
        total++; if (lines !== 24'h0) begin bad++; $display("FAIL reset_lines: got %h want 000000", lines); end
        total++; if (level !== 24'h0) begin bad++; $display("FAIL reset_level: got %h want 000000", level); end
        total++; if (dn !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", dn); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", rdy); end
        total++; if (score4 !== 16'h0 || rdy4 !== 1'b1) begin bad++; $display("FAIL reset_n4: got %h/%b want 0000/1", score4, rdy4); end
    endtask

    task automatic test_single();
        int lat, rh, ch;
        send(3'd1, lat, rh, ch);
        total++; if (lat !== 14) begin bad++; $display("FAIL single_latency: got %0d want 14", lat); end
        total++; if (rh !== 0 || rdy !== 1'b0) begin bad++; $display("FAIL single_ready_low: got %0d high cycles/%b want 0/0", rh, rdy); end
        total++; if (ch !== 0) begin bad++; $display("FAIL single_stable: got %0d early changes want 0", ch); end
        total++; if (score !== 24'h000040) begin bad++; $display("FAIL single_score: got %h want 000040", score); end
        total++; if (lines !== 24'h000001) begin bad++; $display("FAIL single_lines: got %h want 000001", lines); end
        total++; if (level !== 24'h000000) begin bad++; $display("FAIL single_level: got %h want 000000", level); end
        @(negedge clk);
        total++; if (dn !== 1'b0 || rdy !== 1'b1) begin bad++; $display("FAIL single_after: got done=%b ready=%b want 0/1", dn, rdy); end
    endtask

    task automatic test_level_up();
        int lat, rh, ch;
        do_clear();
        repeat (10) send(3'd1, lat, rh, ch);
        total++; if (score !== 24'h000400) begin bad++; $display("FAIL lvl_score10: got %h want 000400", score); end
        total++; if (level !== 24'h000001) begin bad++; $display("FAIL lvl_level10: got %h want 000001", level); end
        total++; if (lines !== 24'h000010) begin bad++; $display("FAIL lvl_lines10: got %h want 000010", lines); end
        send(3'd4, lat, rh, ch);
        total++; if (lat !== 20) begin bad++; $display("FAIL lvl_latency_mult2: got %0d want 20", lat); end
        total++; if (score !== 24'h002800) begin bad++; $display("FAIL lvl_score_mult2: got %h want 002800", score); end
        total++; if (lines !== 24'h000014) begin bad++; $display("FAIL lvl_lines14: got %h want 000014", lines); end
        total++; if (level !== 24'h000001) begin bad++; $display("FAIL lvl_level_keep: got %h want 000001", level); end
    endtask

    task automatic test_clamp();
        int lat, rh, ch;
        send(3'd0, lat, rh, ch);
        total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", lat); end
        total++; if (score !== 24'h002800 || lines !== 24'h000014 || level !== 24'h000001) begin
            bad++; $display("FAIL zero_unchanged: got %h/%h/%h want 002800/000014/000001", score, lines, level); end
        do_clear();
        send(3'd7, lat, rh, ch);
        total++; if (lat !== 14) begin bad++; $display("FAIL clamp_latency: got %0d want 14", lat); end
        total++; if (score !== 24'h001200 || lines !== 24'h000004 || level !== 24'h000000) begin
            bad++; $display("FAIL clamp_values: got %h/%h/%h want 001200/000004/000000", score, lines, level); end
    endtask

    task automatic test_abort();
        int lat, rh, ch, dcount;
        @(negedge clk); ev = 1'b1; el = 3'd4;
        @(posedge clk); #1 ev = 1'b0; el = 3'd0;
        repeat (3) @(negedge clk);
        ng = 1'b1;
        @(posedge clk); #1 ng = 1'b0;
        @(negedge clk);
        total++; if (score !== 24'h0 || lines !== 24'h0 || level !== 24'h0) begin
            bad++; $display("FAIL abort_clear: got %h/%h/%h want zeros", score, lines, level); end
        total++; if (rdy !== 1'b1 || dn !== 1'b0) begin bad++; $display("FAIL abort_ready: got ready=%b done=%b want 1/0", rdy, dn); end
        dcount = 0;
        repeat (30) begin @(negedge clk); if (dn) dcount++; end
        total++; if (dcount !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dcount); end
        send(3'd1, lat, rh, ch);
        total++; if (score !== 24'h000040 || lines !== 24'h000001) begin
            bad++; $display("FAIL abort_next: got %h/%h want 000040/000001", score, lines); end
    endtask

    task automatic test_drop();
        int lat, rh, ch, dcount;
        @(negedge clk); ev = 1'b1; el = 3'd1; ng = 1'b1;
        @(posedge clk); #1 ev = 1'b0; el = 3'd0; ng = 1'b0;
        dcount = 0;
        repeat (30) begin @(negedge clk); if (dn) dcount++; end
        total++; if (dcount !== 0) begin bad++; $display("FAIL drop_ng_done: got %0d pulses want 0", dcount); end
        total++; if (score !== 24'h0 || lines !== 24'h0 || level !== 24'h0) begin
            bad++; $display("FAIL drop_ng_values: got %h/%h/%h want zeros", score, lines, level); end
        send(3'd2, lat, rh, ch);
        total++; if (score !== 24'h000100 || lines !== 24'h000002) begin
            bad++; $display("FAIL drop_sanity: got %h/%h want 000100/000002", score, lines); end
        @(negedge clk); ev = 1'b1; el = 3'd3; rst = 1'b1;
        @(posedge clk); #1 ev = 1'b0; el = 3'd0; rst = 1'b0;
        dcount = 0;
        repeat (30) begin @(negedge clk); if (dn) dcount++; end
        total++; if (dcount !== 0) begin bad++; $display("FAIL drop_rst_done: got %0d pulses want 0", dcount); end
        total++; if (score !== 24'h0 || lines !== 24'h0 || level !== 24'h0 || rdy !== 1'b1) begin
            bad++; $display("FAIL drop_rst_values: got %h/%h/%h ready=%b want zeros/1", score, lines, level, rdy); end
    endtask

    task automatic test_saturation();
        logic [15:0] exp4 [0:8];
        int lat, g;
        exp4 = '{16'h1200, 16'h2400, 16'h3600, 16'h6000, 16'h8400,
                 16'h9999, 16'h9999, 16'h9999, 16'h9999};
        lat = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); ev4 = 1'b1; el4 = 3'd4;
            g = 0;
            while (!rdy4 && g < 500) begin @(negedge clk); g++; end
            @(posedge clk); #1 ev4 = 1'b0; el4 = 3'd0;
            lat = 0;
            while (lat < 200) begin
                @(negedge clk); lat++;
                if (dn4) break;
            end
            total++; if (score4 !== exp4[i]) begin bad++; $display("FAIL sat_score_ev%0d: got %h want %h", i + 1, score4, exp4[i]); end
        end
        total++; if (lat !== 10) begin bad++; $display("FAIL sat_early_done: got %0d want 10", lat); end
        total++; if (lines4 !== 16'h0036) begin bad++; $display("FAIL sat_lines: got %h want 0036", lines4); end
        total++; if (level4 !== 16'h0003) begin bad++; $display("FAIL sat_level: got %h want 0003", level4); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_level_up();
        test_clamp();
        test_abort();
        test_drop();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
